// File: rtl/sram_responder.sv
// sram_responder: shared-array responder for the CPU core's instruction and
// data SRAM interfaces. Each port returns read data through a fixed
// RD_LAT-deep register pipeline that has no stall. The data port writes one
// word per cycle, and a same-word read at the same edge sees the new data
// (write-first).
// Optional feature macro: SRAM_RANGE_CHK_EN adds the sticky addr_err flag and
// the err_addr capture register for the first out-of-range access.
module sram_responder #(
    parameter int unsigned ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h1c00_0000,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_we,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata
`ifdef SRAM_RANGE_CHK_EN
    ,
    output logic        addr_err,
    output logic [31:0] err_addr
`endif
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    generate
        if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
            $error("sram_responder: RD_LAT must be in 1..4");
        end
    endgenerate

    // The offset wraps modulo 2**32, so addresses below BASE_ADDR land far out of range.
    function automatic logic in_range(input logic [31:0] off);
        return (off >> (ADDR_W + 2)) == 32'd0;
    endfunction

    logic [31:0]             mem_q [DEPTH];

    logic [31:0]             inst_off;
    logic [31:0]             data_off;
    logic [ADDR_W-1:0]       inst_idx;
    logic [ADDR_W-1:0]       data_idx;
    logic                    inst_inr;
    logic                    data_inr;
    logic                    wr_en;
    logic [31:0]             inst_rd_d;
    logic [31:0]             data_rd_d;
    logic [RD_LAT-1:0][31:0] inst_pipe_q;
    logic [RD_LAT-1:0][31:0] data_pipe_q;
    logic [RD_LAT-1:0][31:0] inst_pipe_d;
    logic [RD_LAT-1:0][31:0] data_pipe_d;

    assign inst_off = inst_sram_addr - BASE_ADDR;
    assign data_off = data_sram_addr - BASE_ADDR;
    assign inst_idx = inst_off[ADDR_W+1:2];
    assign data_idx = data_off[ADDR_W+1:2];
    assign inst_inr = in_range(inst_off);
    assign data_inr = in_range(data_off);
    assign wr_en    = resetn && data_sram_we && data_inr;

    // The instruction port never writes; its write inputs and the byte-lane bits are deliberately ignored.
    logic unused_bits;
    assign unused_bits = ^{inst_sram_we, inst_sram_wdata, inst_off[1:0], data_off[1:0]};

    // Read selection at the edge: out of range yields 0, a same-word data write forwards wdata.
    always_comb begin
        inst_rd_d = '0;
        data_rd_d = '0;
        if (inst_inr) begin
            if (wr_en && (inst_idx == data_idx)) begin
                inst_rd_d = data_sram_wdata;
            end else begin
                inst_rd_d = mem_q[inst_idx];
            end
        end
        if (data_inr) begin
            if (data_sram_we) begin
                data_rd_d = data_sram_wdata;
            end else begin
                data_rd_d = mem_q[data_idx];
            end
        end
    end

    generate
        if (RD_LAT == 1) begin : g_lat1
            assign inst_pipe_d = inst_rd_d;
            assign data_pipe_d = data_rd_d;
        end else begin : g_latn
            assign inst_pipe_d = {inst_pipe_q[RD_LAT-2:0], inst_rd_d};
            assign data_pipe_d = {data_pipe_q[RD_LAT-2:0], data_rd_d};
        end
    endgenerate

    // Shared word array; contents survive reset, only writes are gated by it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[data_idx] <= data_sram_wdata;
        end
    end

    // Read pipelines advance every cycle; reset flushes in-flight reads at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_pipe_q <= '0;
            data_pipe_q <= '0;
        end else begin
            inst_pipe_q <= inst_pipe_d;
            data_pipe_q <= data_pipe_d;
        end
    end

    assign inst_sram_rdata = inst_pipe_q[RD_LAT-1];
    assign data_sram_rdata = data_pipe_q[RD_LAT-1];

`ifdef SRAM_RANGE_CHK_EN
    logic        addr_err_q;
    logic [31:0] err_addr_q;

    // Sticky capture of the first out-of-range access; the data port wins a same-edge tie.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_err_q <= 1'b0;
            err_addr_q <= '0;
        end else if (!addr_err_q && (!data_inr || !inst_inr)) begin
            addr_err_q <= 1'b1;
            err_addr_q <= !data_inr ? data_sram_addr : inst_sram_addr;
        end
    end

    assign addr_err = addr_err_q;
    assign err_addr = err_addr_q;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Testbench for sram_responder: three instances (RD_LAT 1, 2, 3) share one
// stimulus stream; a word-level reference model pushes expected read data
// into per-instance queues and a monitor pops and compares after each edge.
module tb_sram_responder;

    localparam logic [31:0] BASE = 32'h1c00_0000;
    localparam int          AW   = 12;
    localparam int          NDUT = 3;

    logic        clk;
    logic        resetn;
    logic        iwe;
    logic [31:0] iaddr;
    logic [31:0] iwdata;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] irdata [NDUT];
    logic [31:0] drdata [NDUT];
`ifdef SRAM_RANGE_CHK_EN
    logic        aerr   [NDUT];
    logic [31:0] eaddr  [NDUT];
`endif

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        sram_responder #(
            .ADDR_W   (AW),
            .BASE_ADDR(BASE),
            .RD_LAT   (g + 1)
        ) u_dut (
            .clk            (clk),
            .resetn         (resetn),
            .inst_sram_we   (iwe),
            .inst_sram_addr (iaddr),
            .inst_sram_wdata(iwdata),
            .inst_sram_rdata(irdata[g]),
            .data_sram_we   (dwe),
            .data_sram_addr (daddr),
            .data_sram_wdata(dwdata),
            .data_sram_rdata(drdata[g])
`ifdef SRAM_RANGE_CHK_EN
            ,
            .addr_err       (aerr[g]),
            .err_addr       (eaddr[g])
`endif
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          due;
        logic [31:0] iv;
        logic [31:0] dv;
    } exp_t;

    exp_t        expq   [NDUT][$];
    logic [31:0] cur_i  [NDUT];
    logic [31:0] cur_d  [NDUT];
    logic [31:0] mdl_mem [int];
    bit          m_err;
    logic [31:0] m_eaddr;
    int          edges;
    bit          hold_rst;
    int          nchk;
    int          nbad;

    function automatic bit in_rng(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < (32'd4 << AW);
    endfunction

    function automatic int widx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'(off >> 2);
    endfunction

    function automatic logic [31:0] rd_model(input logic [31:0] a, input bit we,
                                             input logic [31:0] wa, input logic [31:0] wd);
        if (!in_rng(a)) return 32'h0;
        if (we && in_rng(wa) && widx(wa) == widx(a)) return wd;
        if (mdl_mem.exists(widx(a))) return mdl_mem[widx(a)];
        return 32'h0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s at edge %0d: got %h, expected %h", name, edges, act, exp);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge and record what it must produce.
    task automatic step(input logic [31:0] ia, input bit we, input logic [31:0] da,
                        input logic [31:0] wd);
        logic [31:0] ev_i;
        logic [31:0] ev_d;
        @(negedge clk);
        resetn = !hold_rst;
        iaddr  = ia;
        dwe    = we;
        daddr  = da;
        dwdata = wd;
        iwe    = 1'($urandom % 2);
        iwdata = $urandom;
        if (resetn) begin
            ev_i = rd_model(ia, we, da, wd);
            ev_d = rd_model(da, we, da, wd);
            for (int k = 0; k < NDUT; k++) expq[k].push_back('{edges + 1 + k, ev_i, ev_d});
            if (we && in_rng(da)) mdl_mem[widx(da)] = wd;
            if (!m_err && (!in_rng(da) || !in_rng(ia))) begin
                m_err   = 1'b1;
                m_eaddr = !in_rng(da) ? da : ia;
            end
        end
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("%s L%0d inst_rdata", tag, k + 1), irdata[k], 32'h0);
            chk($sformatf("%s L%0d data_rdata", tag, k + 1), drdata[k], 32'h0);
`ifdef SRAM_RANGE_CHK_EN
            chk($sformatf("%s L%0d addr_err", tag, k + 1), {31'h0, aerr[k]}, 32'h0);
            chk($sformatf("%s L%0d err_addr", tag, k + 1), eaddr[k], 32'h0);
`endif
        end
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear without an edge.
    task automatic mid_reset();
        @(negedge clk);
        #2;
        resetn   = 1'b0;
        hold_rst = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            expq[k].delete();
            cur_i[k] = 32'h0;
            cur_d[k] = 32'h0;
        end
        m_err   = 1'b0;
        m_eaddr = 32'h0;
        #1;
        check_zero("mid_reset");
    endtask

    // Monitor: after each rising edge retire due expectations and compare all outputs.
    initial begin
        edges = 0;
        forever begin
            @(posedge clk);
            edges++;
            #3;
            for (int k = 0; k < NDUT; k++) begin
                while (expq[k].size() > 0 && expq[k][0].due <= edges) begin
                    cur_i[k] = expq[k][0].iv;
                    cur_d[k] = expq[k][0].dv;
                    void'(expq[k].pop_front());
                end
                chk($sformatf("L%0d inst_rdata", k + 1), irdata[k], cur_i[k]);
                chk($sformatf("L%0d data_rdata", k + 1), drdata[k], cur_d[k]);
`ifdef SRAM_RANGE_CHK_EN
                chk($sformatf("L%0d addr_err", k + 1), {31'h0, aerr[k]}, {31'h0, m_err});
                chk($sformatf("L%0d err_addr", k + 1), eaddr[k], m_eaddr);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        nchk     = 0;
        nbad     = 0;
        m_err    = 1'b0;
        m_eaddr  = 32'h0;
        hold_rst = 1'b1;
        resetn   = 1'b1;
        iwe      = 1'b0;
        iaddr    = BASE;
        iwdata   = 32'h0;
        dwe      = 1'b0;
        daddr    = BASE;
        dwdata   = 32'h0;
        for (int k = 0; k < NDUT; k++) begin
            cur_i[k] = 32'h0;
            cur_d[k] = 32'h0;
        end
        #1 resetn = 1'b0;
        #1 check_zero("por");
        step(BASE, 1'b1, BASE, 32'h5555_aaaa);
        step(BASE, 1'b1, BASE, 32'h5555_aaaa);
        hold_rst = 1'b0;

        // Preload a 64-word window; the inst port reads the word being written.
        for (int i = 0; i < 64; i++) begin
            ra = BASE + 32'(i * 4);
            step(ra, 1'b1, ra, $urandom);
        end

        // Write then read back on the data port.
        step(BASE + 32'h40, 1'b1, BASE + 32'h10, 32'hdead_beef);
        step(BASE + 32'h40, 1'b0, BASE + 32'h10, 32'h0);

        // Preload 1, 2, 3 then stream them out of the inst port.
        step(BASE + 32'h40, 1'b1, BASE + 32'h0, 32'd1);
        step(BASE + 32'h40, 1'b1, BASE + 32'h4, 32'd2);
        step(BASE + 32'h40, 1'b1, BASE + 32'h8, 32'd3);
        step(BASE + 32'h0, 1'b0, BASE + 32'h40, 32'h0);
        step(BASE + 32'h4, 1'b0, BASE + 32'h40, 32'h0);
        step(BASE + 32'h8, 1'b0, BASE + 32'h40, 32'h0);

        // Same-edge collision between a data write and an inst read.
        step(BASE + 32'h20, 1'b1, BASE + 32'h20, 32'h1234_5678);
        step(BASE + 32'h20, 1'b0, BASE + 32'h24, 32'h0);

        // Misaligned read maps onto the aligned word.
        step(BASE + 32'h13, 1'b0, BASE + 32'h11, 32'h0);

        // Out-of-range write and read, then word 0 must be untouched.
        step(BASE + 32'h40, 1'b1, BASE + 32'h4000, 32'hcafe_f00d);
        step(BASE + 32'h40, 1'b0, BASE + 32'h4000, 32'h0);
        step(BASE + 32'h0, 1'b0, BASE + 32'h0, 32'h0);
        step(32'h1bff_fffc, 1'b1, BASE + 32'h0, 32'h0bad_0bad);
        step(BASE + 32'h0, 1'b0, BASE + 32'h4, 32'h0);

        // Reset in the middle of a stream, then read back preserved contents.
        step(BASE + 32'h10, 1'b1, BASE + 32'h30, 32'h7777_1111);
        step(BASE + 32'h14, 1'b0, BASE + 32'h10, 32'h0);
        mid_reset();
        step(BASE + 32'h30, 1'b1, BASE + 32'h38, 32'hffff_0000);
        step(BASE + 32'h30, 1'b1, BASE + 32'h38, 32'hffff_0000);
        hold_rst = 1'b0;
        step(BASE + 32'h30, 1'b0, BASE + 32'h10, 32'h0);
        step(BASE + 32'h38, 1'b0, BASE + 32'h20, 32'h0);
        step(BASE + 32'h00, 1'b0, BASE + 32'h04, 32'h0);

        // Randomised traffic in the preloaded window with occasional stray addresses.
        for (int n = 0; n < 400; n++) begin
            ra = BASE + 32'(($urandom % 64) * 4 + ($urandom % 4));
            rb = BASE + 32'(($urandom % 64) * 4 + ($urandom % 4));
            if ($urandom % 40 == 0) ra = BASE + 32'h4000 + 32'($urandom % 256);
            if ($urandom % 40 == 0) rb = BASE - 32'd4 - 32'($urandom % 256);
            if ($urandom % 4 == 0) ra = rb;
            step(ra, 1'($urandom % 2), rb, $urandom);
        end

        for (int n = 0; n < 6; n++) step(BASE, 1'b0, BASE + 32'h4, 32'h0);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nbad);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Responder end of the simple SRAM interfaces driven by the multicycle CPU core.
- Serves one read-only instruction port and one read/write data port from a single shared word array.
- Read latency is configurable and returned through a fixed-depth pipeline; the interface has no handshake.
- Sits beside the CPU top in the SoC/testbench and replaces the behavioural RAM models.

Parameters:
- ADDR_W, 12: word-address width; array depth is 2**ADDR_W 32-bit words.
- BASE_ADDR, 32'h1c00_0000: byte address mapped to word 0.
- RD_LAT, 1: read latency in cycles; legal range 1..4. Other values are an elaboration error.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- resetn  input  1  asynchronous active-low reset.
- inst_sram_we  input  1  must be 0; writes on this port are ignored.
- inst_sram_addr  input  32  instruction byte address.
- inst_sram_wdata  input  32  unused.
- inst_sram_rdata  output  32  instruction read data.
- data_sram_we  input  1  data write enable, one word per cycle.
- data_sram_addr  input  32  data byte address.
- data_sram_wdata  input  32  data write data.
- data_sram_rdata  output  32  data read data.

Behaviour:
- Address mapping:
  - off = addr - BASE_ADDR, computed modulo 2**32.
  - word index = off[ADDR_W+1:2].
  - addr[1:0] is ignored.
  - The address is in range iff off < 4*2**ADDR_W.
- Read pipeline:
  - Each port has an RD_LAT-stage register pipeline that advances every cycle; there is no stall or enable.
  - The address sampled at edge N produces read data on rdata after edge N+RD_LAT-1, i.e. stable during cycle N+RD_LAT.
  - rdata holds until the pipeline delivers the next word.
  - With RD_LAT=1 this is a plain synchronous RAM.
- Out-of-range read: the pipeline carries 32'h0.
- Write:
  - When data_sram_we=1, resetn=1 and the address is in range, mem[index] <= wdata at the edge.
  - Out-of-range writes are dropped silently.
- Collisions, write-first:
  - A data-port write and a read of the same word at the same edge, from either port, return the new wdata.
  - A read on the following edge returns the new value.
- inst_sram_we=1 has no effect on the array.
- Reset (resetn low):
  - Immediately clears all pipeline stages.
  - inst_sram_rdata=0 and data_sram_rdata=0.
  - The array is not cleared and keeps its contents.
  - No writes occur while resetn is low.
- Reset mid-operation:
  - In-flight reads are discarded.
  - After release, outputs stay 0 until the first post-reset read reaches the pipeline end, RD_LAT cycles later.
- The array is not initialised; the bench preloads it with $readmemh on the array instance or through port writes.

Optional Feature:
- Macro: SRAM_RANGE_CHK_EN.
- Defined:
  - Adds output addr_err (1 bit) and output err_addr (32 bits). Both reset to 0.
  - addr_err is a sticky flag: it sets on the first edge where a data-port access (read or write) or an inst-port read is out of range, and stays set until reset.
  - err_addr captures the byte address of that first offending access.
  - When both ports are out of range on the same edge, err_addr captures the data port's address.
  - Later errors do not update either output.
- Undefined:
  - Neither port exists.
  - Out-of-range behaviour is otherwise identical: reads return 0 and writes are dropped.

Test Plan:
- RD_LAT=1: write 32'hdead_beef to 0x1c00_0010, then read it from the data port one cycle later -> data_sram_rdata = 32'hdead_beef in the cycle after the address is presented.
- RD_LAT=3: present 0x1c00_0000, 0x1c00_0004, 0x1c00_0008 on consecutive cycles on the inst port, after preloading 1, 2, 3 -> inst_sram_rdata reads 1, 2, 3 on consecutive cycles, starting 3 cycles after the first address.
- Collision: data write of 32'h1234_5678 to 0x1c00_0020 while the inst port reads the same address on the same edge -> inst_sram_rdata = 32'h1234_5678.
- Out of range:
  - Stimulus: data write to 0x1c00_4000 with ADDR_W=12, then a read of the same address; next, a read of 0x1c00_0000.
  - Response: the out-of-range read returns 0 and word 0 is unchanged.
  - With SRAM_RANGE_CHK_EN: addr_err=1 and err_addr=32'h1c00_4000.
- Reset: assert resetn low mid-stream with RD_LAT=2 -> both rdata go 0 immediately, not on the next edge; array contents are preserved and still readable after release.
- Misaligned address: read 0x1c00_0013 -> returns the same word as 0x1c00_0010.
